// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage and IF/ID pipeline register with variable-latency imem handshake
//
// Purpose:
//   Owns PCF, issues level-held fetch requests to instruction memory,
//   buffers one returned word while decode is stalled, applies EX/WB
//   redirects and loads the IF/ID register (or a bubble) every cycle.
//
// Parameters:
//   RESET_PC   PCF value after reset
//   NOP_INSTR  InstrD value for a bubble
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   StallF, StallD, FlushD      hazard unit controls
//   BranchTakenE, ALUResultE    EX-stage redirect and target
//   PCSrcW, ResultW             WB-stage redirect (R15 write) and target
//   imem_req, imem_addr         fetch request (level) and address
//   imem_valid, imem_rdata      one-cycle response strobe and word
//   InstrD, ValidD, PCPlus8D    IF/ID register contents
//   CondD, OpD, FunctD, RdD     instruction fields of InstrD
//   FetchBusyF                  no instruction available this cycle
//   FetchCount, BubbleCount     performance counters
//
// Configuration:
//   FETCH_PERF_EN  when defined, FetchCount/BubbleCount count accepts and
//                  bubble loads; otherwise both are tied to zero.

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic        ValidD,
    output logic [31:0] PCPlus8D,
    output logic [3:0]  CondD,
    output logic [1:0]  OpD,
    output logic [5:0]  FunctD,
    output logic [3:0]  RdD,
    output logic        FetchBusyF,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pcf;
    logic        hb_valid;
    logic [31:0] hb_data;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        req_active;
    logic        resp_live;
    logic        avail;
    logic [31:0] fetch_word;
    logic        accept;

    always_comb begin
        redirect        = BranchTakenE | PCSrcW;
        // EX is younger in program order than WB's target source, so it wins.
        redirect_target = BranchTakenE ? ALUResultE : ResultW;
        // A buffered word must be drained before a new request goes out.
        req_active      = (state != S_DROP) && !hb_valid;
        resp_live       = req_active && imem_valid;
        avail           = hb_valid || resp_live;
        fetch_word      = hb_valid ? hb_data : imem_rdata;
        accept          = avail && !StallF && !StallD && !redirect;

        state_next = state;
        case (state)
            S_FETCH, S_WAIT: begin
                if (hb_valid || imem_valid) begin
                    state_next = S_FETCH;
                end else if (redirect) begin
                    // The outstanding request already targets the old PC;
                    // its response must be swallowed before refetching.
                    state_next = S_DROP;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_DROP: begin
                if (imem_valid) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            pcf      <= RESET_PC;
            hb_valid <= 1'b0;
            hb_data  <= NOP_INSTR;
        end else begin
            state <= state_next;
            if (redirect) begin
                pcf      <= redirect_target;
                hb_valid <= 1'b0;
            end else if (accept) begin
                pcf      <= pcf + 32'd4;
                hb_valid <= 1'b0;
            end else if (resp_live) begin
                // Not accepted and no redirect: fetch is stalled, park the word.
                hb_valid <= 1'b1;
                hb_data  <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            ValidD   <= 1'b0;
            PCPlus8D <= RESET_PC + 32'd8;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (StallD) begin
            InstrD   <= InstrD;
            ValidD   <= ValidD;
            PCPlus8D <= PCPlus8D;
        end else if (accept) begin
            InstrD   <= fetch_word;
            ValidD   <= 1'b1;
            PCPlus8D <= pcf + 32'd8;
        end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if (accept) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (FlushD || (!StallD && !accept)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end

    assign FetchCount  = fetch_cnt;
    assign BubbleCount = bubble_cnt;
`else
    assign FetchCount  = 32'd0;
    assign BubbleCount = 32'd0;
`endif

    assign imem_req   = req_active;
    assign imem_addr  = pcf;
    assign FetchBusyF = !avail;
    assign CondD      = InstrD[31:28];
    assign OpD        = InstrD[27:26];
    assign FunctD     = InstrD[25:20];
    assign RdD        = InstrD[15:12];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage

module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        BranchTakenE = 1'b0;
    logic [31:0] ALUResultE = 32'd0;
    logic        PCSrcW = 1'b0;
    logic [31:0] ResultW = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] InstrD;
    logic        ValidD;
    logic [31:0] PCPlus8D;
    logic [3:0]  CondD;
    logic [1:0]  OpD;
    logic [5:0]  FunctD;
    logic [3:0]  RdD;
    logic        FetchBusyF;
    logic [31:0] FetchCount;
    logic [31:0] BubbleCount;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW), .ResultW(ResultW),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .ValidD(ValidD), .PCPlus8D(PCPlus8D),
        .CondD(CondD), .OpD(OpD), .FunctD(FunctD), .RdD(RdD),
        .FetchBusyF(FetchBusyF), .FetchCount(FetchCount), .BubbleCount(BubbleCount)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_loads = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 0;
        if (r < 8) return 1;
        if (r < 9) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] pick_target();
        if ($urandom_range(0, 9) == 0)
            return 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
        return 32'($urandom_range(0, 2047)) << 2;
    endfunction

    // ---------------- memory model: latches address at request start ----
    int          force_lat = -1;
    bit          m_busy = 1'b0;
    int          m_lat = 0;
    int          m_age = 0;
    logic [31:0] m_addr = 32'd0;

    initial forever begin
        @(posedge clk);
        #2;
        if (reset) begin
            m_busy     = 1'b0;
            imem_valid = 1'b0;
        end else begin
            if (imem_valid) begin
                m_busy     = 1'b0;
                imem_valid = 1'b0;
            end
            if (m_busy) begin
                if (imem_req) chk("imem_addr_held", imem_addr, m_addr);
                m_lat--;
                m_age++;
                if (m_lat <= 0) imem_valid = 1'b1;
            end else if (imem_req) begin
                m_busy = 1'b1;
                m_addr = imem_addr;
                m_age  = 0;
                if (force_lat >= 0) begin
                    m_lat     = force_lat;
                    force_lat = -1;
                end else begin
                    m_lat = pick_lat();
                end
                if (m_lat == 0) imem_valid = 1'b1;
            end
        end
        imem_rdata = imem_valid ? mem_word(m_addr) : 32'hDEAD_BEEF;
    end

    // ---------------- stimulus driver -----------------------------------
    int mode = 0;  // 0 idle, 1 random, 2 one-cycle dual redirect

    initial forever begin
        int r;
        @(posedge clk);
        #1;
        if (mode == 1) begin
            StallD       = ($urandom_range(0, 99) < 15);
            StallF       = StallD | ($urandom_range(0, 99) < 5);
            r            = $urandom_range(0, 99);
            BranchTakenE = (r < 4);
            PCSrcW       = (r >= 2 && r < 7);
            ALUResultE   = pick_target();
            ResultW      = pick_target();
            FlushD       = (BranchTakenE | PCSrcW) && ($urandom_range(0, 1) == 1);
        end else if (mode == 2) begin
            StallD = 1'b1; StallF = 1'b1; FlushD = 1'b1;
            BranchTakenE = 1'b1; ALUResultE = 32'h0000_0200;
            PCSrcW = 1'b1; ResultW = 32'h0000_0300;
            mode = 0;
        end else begin
            StallD = 1'b0; StallF = 1'b0; FlushD = 1'b0;
            BranchTakenE = 1'b0; PCSrcW = 1'b0;
            ALUResultE = 32'd0; ResultW = 32'd0;
        end
    end

    // ---------------- monitor / scoreboard ------------------------------
    logic [31:0] exp_q[$];
    logic        p_reset = 1'b1;
    logic        p_stalld = 1'b0;
    logic        p_flushd = 1'b0;
    logic [31:0] p_instr = 32'd0;
    logic        p_valid = 1'b0;
    logic [31:0] p_pc8 = 32'd0;
    logic [31:0] m_fetch = 32'd0;
    logic [31:0] m_bub = 32'd0;

    initial forever begin
        logic [31:0] pc;
        logic [31:0] w;
        @(negedge clk);
        if (p_reset) begin
            chk("reset_validd", {31'd0, ValidD}, 32'd0);
            chk("reset_instrd", InstrD, NOP_INSTR);
            chk("reset_pcplus8d", PCPlus8D, RESET_PC + 32'd8);
            exp_q.delete();
            exp_q.push_back(RESET_PC);
            m_fetch = 32'd0;
            m_bub   = 32'd0;
        end else if (p_flushd || (!p_stalld && !ValidD)) begin
            chk("bubble_validd", {31'd0, ValidD}, 32'd0);
            chk("bubble_instrd", InstrD, NOP_INSTR);
            chk("bubble_pcplus8d", PCPlus8D, p_pc8);
            m_bub++;
        end else if (p_stalld) begin
            chk("hold_instrd", InstrD, p_instr);
            chk("hold_validd", {31'd0, ValidD}, {31'd0, p_valid});
            chk("hold_pcplus8d", PCPlus8D, p_pc8);
        end else begin
            n_loads++;
            m_fetch++;
            if (exp_q.size() == 0) begin
                chk("exp_queue_nonempty", 32'd0, 32'd1);
            end else begin
                pc = exp_q.pop_front();
                w  = mem_word(pc);
                exp_q.push_back(pc + 32'd4);
                chk("load_pcplus8d", PCPlus8D, pc + 32'd8);
                chk("load_instrd", InstrD, w);
                chk("load_fields", {CondD, OpD, FunctD, RdD}, {16'd0, w[31:28], w[27:26], w[25:20], w[15:12]});
            end
        end
`ifdef FETCH_PERF_EN
        chk("fetch_count", FetchCount, m_fetch);
        chk("bubble_count", BubbleCount, m_bub);
`else
        chk("fetch_count_off", FetchCount, 32'd0);
        chk("bubble_count_off", BubbleCount, 32'd0);
`endif
        // Program order restarts at the redirect target (EX beats WB).
        if (!reset && (BranchTakenE || PCSrcW)) begin
            exp_q.delete();
            exp_q.push_back(BranchTakenE ? ALUResultE : ResultW);
        end
        p_reset  = reset;
        p_stalld = StallD;
        p_flushd = FlushD;
        p_instr  = InstrD;
        p_valid  = ValidD;
        p_pc8    = PCPlus8D;
    end

    // ---------------- main sequence -------------------------------------
    initial begin
        bit found;
        force_lat = 3;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Slow first fetch: busy for three cycles, then the word is available.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("slow_busy", {31'd0, FetchBusyF}, 32'd1);
            chk("slow_req", {31'd0, imem_req}, 32'd1);
            chk("slow_addr", imem_addr, RESET_PC);
        end
        @(negedge clk);
        chk("slow_avail", {31'd0, FetchBusyF}, 32'd0);

        mode = 1;
        repeat (3000) @(negedge clk);
        mode = 0;
        repeat (10) @(negedge clk);

        // Simultaneous EX and WB redirect with FlushD and StallD.
        mode = 2;
        @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req) found = 1'b1;
        end
        chk("dual_redirect_req", {31'd0, found}, 32'd1);
        chk("dual_redirect_addr", imem_addr, 32'h0000_0200);
        repeat (10) @(negedge clk);

        // Reset while a request is waiting on memory.
        force_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (m_busy && m_age >= 1 && m_lat >= 1) found = 1'b1;
        end
        chk("mid_wait_reached", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_req", {31'd0, imem_req}, 32'd1);
        chk("post_reset_addr", imem_addr, RESET_PC);
        repeat (20) @(negedge clk);

        chk("progress", {31'd0, (n_loads > 300)}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
